// File: rtl/module_cpu_control.sv
// Mini-CPU instruction sequencer. Each start pulse runs one 18-bit instruction.
// It reads operands from the register memory, drives the external ALU, writes
// the result back and then raises a single display-update pulse.
// Optional feature: define CTRL_OVF_FLAG_EN to add the signed-overflow flag
// output ovf.
// Handshake: start is taken only while busy=0. mem_rd_en returns mem_rdata
// one cycle later. mem_we writes in the same cycle it is high. done and
// disp_en pulse high together for exactly one cycle.
module module_cpu_control #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [17:0]       instr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              disp_en,
  output logic [2:0]        disp_opcode,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_value,
`ifdef CTRL_OVF_FLAG_EN
  output logic              ovf,
`endif
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_RD1    = 4'd2;
  localparam logic [3:0] S_RD1W   = 4'd3;
  localparam logic [3:0] S_RD2    = 4'd4;
  localparam logic [3:0] S_RD2W   = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_WB     = 4'd7;
  localparam logic [3:0] S_CLR    = 4'd8;
  localparam logic [3:0] S_DISP   = 4'd9;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DISP = 3'b111;

  logic [3:0]        state, state_nxt;
  logic [17:0]       ins;
  logic [DATA_W-1:0] reg_a, reg_b, result;
  logic [ADDR_W-1:0] clr_cnt;

  logic [2:0]        opcode;
  logic [ADDR_W-1:0] dst, src1, src2;
  logic [DATA_W-1:0] imm_ext;

  assign opcode    = ins[17:15];
  assign dst       = ins[11 +: ADDR_W];
  assign src1      = ins[7 +: ADDR_W];
  assign src2      = ins[3 +: ADDR_W];
  assign imm_ext   = {{(DATA_W-IMM_W){ins[IMM_W-1]}}, ins[IMM_W-1:0]};
  assign dbg_state = state;

  // Next-state selection; the instruction path is chosen from the latched opcode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LOAD)     state_nxt = S_WB;
        else if (opcode == OP_CLR) state_nxt = S_CLR;
        else                       state_nxt = S_RD1;
      end
      S_RD1:    state_nxt = S_RD1W;
      S_RD1W: begin
        if (opcode == OP_DISP)                             state_nxt = S_DISP;
        else if (opcode == OP_ADDI || opcode == OP_SUBI)   state_nxt = S_EXEC;
        else                                               state_nxt = S_RD2;
      end
      S_RD2:    state_nxt = S_RD2W;
      S_RD2W:   state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_DISP;
      S_CLR:    if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = S_DISP;
      S_DISP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, operand, result and display registers; reset aborts any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ins         <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      result      <= '0;
      clr_cnt     <= '0;
      disp_opcode <= '0;
      disp_addr   <= '0;
      disp_value  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:   if (start) ins <= instr;
        S_DECODE: begin
          clr_cnt <= '0;
          if (opcode == OP_LOAD) result <= imm_ext;
          if (opcode == OP_ADDI || opcode == OP_SUBI) reg_b <= imm_ext;
        end
        S_RD1W:   reg_a   <= mem_rdata;
        S_RD2W:   reg_b   <= mem_rdata;
        S_EXEC:   result  <= alu_result;
        S_CLR:    clr_cnt <= clr_cnt + 1'b1;
        default:  ;
      endcase
      // Display fields are captured once, on entry to DISP, and then held.
      if (state_nxt == S_DISP && state != S_DISP) begin
        disp_opcode <= opcode;
        if (opcode == OP_DISP) begin
          disp_addr  <= src1;
          disp_value <= mem_rdata;
        end else if (opcode == OP_CLR) begin
          disp_addr  <= '0;
          disp_value <= '0;
        end else begin
          disp_addr  <= dst;
          disp_value <= result;
        end
      end
    end
  end

`ifdef CTRL_OVF_FLAG_EN
  // Signed overflow from operand and result signs; DISPLAY leaves the flag alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == S_DECODE && (opcode == OP_LOAD || opcode == OP_CLR)) begin
      ovf <= 1'b0;
    end else if (state == S_EXEC) begin
      if (opcode == OP_ADD || opcode == OP_ADDI)
        ovf <= (reg_a[DATA_W-1] == reg_b[DATA_W-1]) && (alu_result[DATA_W-1] != reg_a[DATA_W-1]);
      else if (opcode == OP_SUB || opcode == OP_SUBI)
        ovf <= (reg_a[DATA_W-1] != reg_b[DATA_W-1]) && (alu_result[DATA_W-1] != reg_a[DATA_W-1]);
      else
        ovf <= 1'b0;
    end
  end
`endif

  // Output decode from state; idle outputs are all zero except alu_op = NADA.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DISP);
    disp_en   = (state == S_DISP);
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    alu_op    = 2'b11;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_RD1: begin
        mem_addr  = src1;
        mem_rd_en = 1'b1;
      end
      S_RD2: begin
        mem_addr  = src2;
        mem_rd_en = 1'b1;
      end
      S_EXEC: begin
        alu_a = reg_a;
        alu_b = reg_b;
        if (opcode == OP_ADD || opcode == OP_ADDI)      alu_op = 2'b00;
        else if (opcode == OP_SUB || opcode == OP_SUBI) alu_op = 2'b01;
        else if (opcode == OP_MUL)                      alu_op = 2'b10;
        else                                            alu_op = 2'b11;
      end
      S_WB: begin
        mem_we    = 1'b1;
        mem_addr  = dst;
        mem_wdata = result;
      end
      S_CLR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_module_cpu_control.sv
// Directed bench for module_cpu_control with a register-memory and ALU model.
module tb_module_cpu_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [17:0] instr = '0;
  logic        busy, done, mem_rd_en, mem_we, disp_en;
  logic [3:0]  mem_addr, disp_addr, dbg_state;
  logic [15:0] mem_rdata, mem_wdata, alu_a, alu_b, alu_result, disp_value;
  logic [1:0]  alu_op;
  logic [2:0]  disp_opcode;
`ifdef CTRL_OVF_FLAG_EN
  logic        ovf;
`endif

  module_cpu_control dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_addr(disp_addr),
    .disp_value(disp_value),
`ifdef CTRL_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- memory and ALU models ----------------
  logic [15:0] mem [16];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;
  logic [31:0] prod;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr]  <= bd_data;
    if (mem_rd_en)  mem_rdata     <= mem[mem_addr];
  end

  always_comb begin
    prod = 32'(alu_a) * 32'(alu_b);
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = prod[15:0];
      default: alu_result = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  int         done_cyc, we_cnt, first_we, disp_cnt;
  logic       clr_ok;
  logic [1:0] op_at [64];

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Runs one instruction; cycle 1 is DECODE. extra_cyc raises a second start
  // during that cycle; rst_cyc asserts reset during that cycle and stops.
  task automatic run_instr(input logic [17:0] ins, input int extra_cyc, input int rst_cyc);
    done_cyc = 0; we_cnt = 0; first_we = 0; disp_cnt = 0; clr_ok = 1'b1;
    for (int i = 0; i < 64; i++) op_at[i] = 2'b11;
    @(negedge clk);
    instr = ins; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      op_at[cyc] = alu_op;
      if (mem_we) begin
        if (we_cnt == 0) first_we = cyc;
        if (mem_addr != 4'(we_cnt) || mem_wdata != 16'h0) clr_ok = 1'b0;
        we_cnt++;
      end
      if (disp_en) disp_cnt++;
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_alu_op", alu_op, 2'b11);
        chk("rst_disp_en", disp_en, 0);
        chk("rst_disp_value", disp_value, 0);
        @(negedge clk);
        chk("rst_we_held", mem_we, 0);
        rst_n = 1'b1;
        break;
      end
      if (done) begin
        done_cyc = cyc;
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        break;
      end
      if (cyc == extra_cyc) begin
        start = 1'b1;
        instr = {3'b000, 4'd15, 4'd0, 7'h11};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic logic [17:0] r_ins(input logic [2:0] op, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [17:0] i_ins(input logic [2:0] op, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [6:0] imm);
    return {op, d, s1, imm};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_alu_op", alu_op, 2'b11);
    chk("reset_disp_value", disp_value, 0);
    chk("reset_state", dbg_state, 0);
`ifdef CTRL_OVF_FLAG_EN
    chk("reset_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    // LOAD r3 <- -5
    run_instr(i_ins(3'b000, 4'd3, 4'd0, 7'h7B), 0, 0);
    chk("load_done_cyc", done_cyc, 3);
    chk("load_we_cyc", first_we, 2);
    chk("load_we_cnt", we_cnt, 1);
    chk("load_mem3", mem[3], 16'hFFFB);
    chk("load_disp_value", disp_value, 16'hFFFB);
    chk("load_disp_addr", disp_addr, 3);
    chk("load_disp_op", disp_opcode, 0);
    chk("load_disp_cnt", disp_cnt, 1);

    run_instr(i_ins(3'b000, 4'd1, 4'd0, 7'd7), 0, 0);
    run_instr(i_ins(3'b000, 4'd2, 4'd0, 7'd9), 0, 0);

    // ADD r4 = r1 + r2 = 16
    run_instr(r_ins(3'b001, 4'd4, 4'd1, 4'd2), 0, 0);
    chk("add_done_cyc", done_cyc, 8);
    chk("add_op_c6", op_at[6], 2'b00);
    chk("add_op_c5", op_at[5], 2'b11);
    chk("add_we_cyc", first_we, 7);
    chk("add_mem4", mem[4], 16'h0010);
    chk("add_disp_value", disp_value, 16'h0010);
    chk("add_disp_op", disp_opcode, 3'b001);

    // MUL r6 = r5 * r5 = 0x10000 -> wraps to 0
    poke(4'd5, 16'h0100);
    poke(4'd6, 16'hAAAA);
    run_instr(r_ins(3'b101, 4'd6, 4'd5, 4'd5), 0, 0);
    chk("mul_done_cyc", done_cyc, 8);
    chk("mul_op_c6", op_at[6], 2'b10);
    chk("mul_mem6", mem[6], 16'h0000);

    // SUBI r8 = r7 - 7 = 5 - 7 = -2
    run_instr(i_ins(3'b000, 4'd7, 4'd0, 7'd5), 0, 0);
    run_instr(i_ins(3'b100, 4'd8, 4'd7, 7'd7), 0, 0);
    chk("subi_done_cyc", done_cyc, 6);
    chk("subi_op_c4", op_at[4], 2'b01);
    chk("subi_mem8", mem[8], 16'hFFFE);

    // DISPLAY r4: no write, shows src1 and its value
    run_instr(r_ins(3'b111, 4'd9, 4'd4, 4'd0), 0, 0);
    chk("disp_done_cyc", done_cyc, 4);
    chk("disp_we_cnt", we_cnt, 0);
    chk("disp_value", disp_value, 16'h0010);
    chk("disp_addr", disp_addr, 4);
    chk("disp_op", disp_opcode, 3'b111);

    // ADDI r9 = r3 + (-1) = -6
    run_instr(i_ins(3'b010, 4'd9, 4'd3, 7'h7F), 0, 0);
    chk("addi_done_cyc", done_cyc, 6);
    chk("addi_mem9", mem[9], 16'hFFFA);

    // SUB r10 = r2 - r1 = 2
    run_instr(r_ins(3'b011, 4'd10, 4'd2, 4'd1), 0, 0);
    chk("sub_done_cyc", done_cyc, 8);
    chk("sub_op_c6", op_at[6], 2'b01);
    chk("sub_mem10", mem[10], 16'h0002);

`ifdef CTRL_OVF_FLAG_EN
    poke(4'd12, 16'h7FFF);
    poke(4'd13, 16'h0001);
    run_instr(r_ins(3'b001, 4'd14, 4'd12, 4'd13), 0, 0);
    chk("ovf_add_mem14", mem[14], 16'h8000);
    chk("ovf_add_flag", ovf, 1);
    run_instr(i_ins(3'b000, 4'd0, 4'd0, 7'd1), 0, 0);
    chk("ovf_load_clear", ovf, 0);
`endif

    // CLEAR with an ignored second start during cycle 5
    run_instr(r_ins(3'b110, 4'd5, 4'd6, 4'd7), 5, 0);
    chk("clr_done_cyc", done_cyc, 18);
    chk("clr_we_cnt", we_cnt, 16);
    chk("clr_first_we", first_we, 2);
    chk("clr_seq", clr_ok, 1);
    chk("clr_mem3", mem[3], 0);
    chk("clr_mem10", mem[10], 0);
    chk("clr_disp_addr", disp_addr, 0);
    chk("clr_disp_value", disp_value, 0);
    chk("clr_disp_op", disp_opcode, 3'b110);
    chk("clr_disp_cnt", disp_cnt, 1);
    chk("clr_no_requeue", busy, 0);

    // Reset during RD2 of an ADD: aborted, destination untouched
    poke(4'd1, 16'd7);
    poke(4'd2, 16'd9);
    poke(4'd11, 16'h1234);
    run_instr(r_ins(3'b001, 4'd11, 4'd1, 4'd2), 0, 4);
    chk("abort_we_cnt", we_cnt, 0);
    repeat (8) @(negedge clk);
    chk("abort_mem11", mem[11], 16'h1234);
    chk("abort_idle", busy, 0);

    run_instr(i_ins(3'b000, 4'd11, 4'd0, 7'd3), 0, 0);
    chk("post_rst_load_cyc", done_cyc, 3);
    chk("post_rst_mem11", mem[11], 16'h0003);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
